text_terminal_writer: RTL and testbench
=======================================

# text_terminal_writer

Hardware terminal front-end: accepts a stream of ASCII bytes from the CPU IO page and writes them into the 80×30 character memory that the text pixel pipeline reads. It is the writer side of that memory and maintains the cursor. It handles CR, LF, BS and FF, auto-wraps at the line end, and scrolls at the bottom. It owns one request/grant port into the character memory, arbitrated against the CPU and video slots.

## Interface
- `COLS`, default 80: characters per row.
- `ROWS`, default 30: rows (480 lines / 16).
- `ADDR_W`, default 12: character memory address width.
- `clk`, in, 1: system clock (25 MHz).
- `reset`, in, 1: synchronous active-high reset; one clock (`clk`).
- `in_valid`, in, 1: byte offered.
- `in_data`, in, 8: bits [6:0] are ASCII; bit 7 is the highlight flag, stored unchanged.
- `in_ready`, out, 1: byte accepted when `in_valid & in_ready`.
- `mem_req`, out, 1: memory access request.
- `mem_gnt`, in, 1: access performed at this edge if `mem_req`.
- `mem_we`, out, 1: 1 = write, 0 = read.
- `mem_addr`, out, ADDR_W: address = y*COLS + x, range 0..2399.
- `mem_wdata`, out, 8: write byte.
- `mem_rdata`, in, 8: read data, valid the cycle after a granted read.
- `cursor_x`, out, 7: cursor column, 0..COLS-1.
- `cursor_y`, out, 5: cursor row, 0..ROWS-1.
- `busy`, out, 1: equals `~in_ready`.

## Operation
- **States:** IDLE, WRITE, SCROLL_RD, SCROLL_CAP, SCROLL_WR, CLEAR.
  - `in_ready` = (state == IDLE).
  - Reset: state IDLE, cursor (0,0), `mem_req`/`mem_we`/`mem_addr`/`mem_wdata` = 0.
- **Request rule:** while `mem_req` is high, `mem_we`, `mem_addr` and `mem_wdata` are held stable until a granted edge. Nothing advances without `mem_gnt`.
- **Decode** of an accepted byte, on `in_data[6:0]`:
  - 0x20–0x7E: go to WRITE at the cursor with the full 8-bit byte. On grant, x+1.
    - If x was COLS-1: x=0 and perform newline.
  - 0x0D (CR): x=0. Stays IDLE.
  - 0x0A (LF): newline.
  - 0x08 (BS): x-1 if x>0, else unchanged. No memory write.
  - 0x0C (FF): CLEAR the whole screen with 0x20 at addresses 0..2399, then cursor (0,0).
  - All other codes, including 0x7F: ignored, stay IDLE.
- **Newline:**
  - y < ROWS-1: y+1.
  - y = ROWS-1: scroll; y stays ROWS-1.
- **Scroll:** for i = 0..(ROWS-1)*COLS-1:
  - SCROLL_RD reads address i+COLS.
  - SCROLL_CAP latches `mem_rdata` into `mem_wdata`.
  - SCROLL_WR writes address i.
  - Then CLEAR the last row (addresses 2320..2399) with 0x20, then IDLE.
- **Simultaneous events:** a printable byte at x=COLS-1 on the last row performs WRITE, then scroll, as one accepted byte. Cursor outputs update at the edge that completes the causing step.
- **Reset mid-operation:** aborts at once. Memory contents stay partially updated. No further requests.

## Timing
- All outputs are registered except `in_ready`/`busy`, which are decoded from state.
- Byte accepted at edge N, `mem_gnt` held high:
  - Printable byte: `mem_req` high in cycle N..N+1, write and cursor update at edge N+1, `in_ready` high again after edge N+1. Throughput is one byte per 2 cycles.
  - CR and BS: complete at edge N, no busy cycle.
  - Scroll: 3 cycles per moved character plus 1 per cleared character. IDLE after edge N+7040.
  - FF: IDLE after edge N+2400.
- Denied grants stretch each step by one cycle per denied edge.

## Configuration
- `TERM_SCROLL_EN` defined: newline on the last row scrolls, as described above.
- `TERM_SCROLL_EN` undefined:
  - Newline on the last row sets y=0 and CLEARs row 0 (addresses 0..79); no scroll.
  - SCROLL_* states are not compiled.
  - Newline wrap takes 80 cycles.

## Structure
- Shared package `term_pkg`:
  - Constants: COLS, ROWS, SCREEN_SIZE=2400, CHAR_SPACE=0x20.
  - Control codes: CR, LF, BS, FF.
  - State enum.
- One sub-module `term_addr_seq`: loadable address counter with start, end and done flag, used by scroll and CLEAR.

## Test plan
- **Print with wrap:** reset, send "AB" -> writes 0x41 at addr 0 and 0x42 at addr 1, cursor (2,0). Send 78 more 'x' -> cursor (0,1).
- **CR, LF, BS:** 'Q' then CR, LF, BS -> cursor (0,1), BS leaves x=0, no memory writes after the 'Q'. From (5,3), BS -> (4,3).
- **Scroll:** preload row1 = 0x31s, move the cursor to (0,29), send LF -> row0 holds 0x31s, row29 all 0x20. `in_ready` high again exactly 7040 edges after acceptance. Without `TERM_SCROLL_EN`: cursor (0,0), row0 = 0x20, 80 cycles.
- **Grant stall:** `mem_gnt` low for 5 cycles during a write -> `mem_addr`/`mem_wdata` stable throughout, exactly one write, cursor advances only at the grant edge.
- **FF and highlight:** send 0xC1 then FF -> addr 0 briefly holds 0xC1, then all 2400 locations = 0x20, cursor (0,0). Send 0x07 -> ignored.
- **Reset mid-scroll:** assert `reset` 100 cycles into a scroll -> next edge `mem_req`=0, cursor (0,0), `in_ready`=1.

Source files
------------

// File: rtl/term_pkg.sv
// ============================================================================
// Module   : term_pkg
// Brief    : Shared constants, control codes and FSM states for the text
//            terminal writer. Optional macro: TERM_SCROLL_EN (scroll states).
// Revision : 1.0
// ============================================================================
`default_nettype none

package term_pkg;

  localparam int TERM_COLS   = 80;
  localparam int TERM_ROWS   = 30;
  localparam int SCREEN_SIZE = TERM_COLS * TERM_ROWS;

  localparam logic [7:0] CHAR_SPACE = 8'h20;

  localparam logic [6:0] CODE_BS       = 7'h08;
  localparam logic [6:0] CODE_LF       = 7'h0A;
  localparam logic [6:0] CODE_FF       = 7'h0C;
  localparam logic [6:0] CODE_CR       = 7'h0D;
  localparam logic [6:0] CODE_PRINT_LO = 7'h20;
  localparam logic [6:0] CODE_PRINT_HI = 7'h7E;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITE      = 3'd1,
    ST_CLEAR      = 3'd2
`ifdef TERM_SCROLL_EN
    ,
    ST_SCROLL_RD  = 3'd3,
    ST_SCROLL_CAP = 3'd4,
    ST_SCROLL_WR  = 3'd5
`endif
  } term_state_e;

endpackage

`default_nettype wire

// File: rtl/term_addr_seq.sv
// ============================================================================
// Module   : term_addr_seq
// Brief    : Loadable address counter (start/end/done) driving bulk scroll
//            and clear sweeps. Optional macro: none.
// Revision : 1.0
// ============================================================================
`default_nettype none

module term_addr_seq
  import term_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_start,
  input  logic [ADDR_W-1:0] i_end,
  input  logic              i_step,
  output logic [ADDR_W-1:0] o_cur,
  output logic [ADDR_W-1:0] o_next,
  output logic              o_done
);

  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] r_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur <= '0;
      r_end <= '0;
    end else if (i_load) begin
      r_cur <= i_start;
      r_end <= i_end;
    end else if (i_step && (r_cur != r_end)) begin
      r_cur <= r_cur + 1'b1;
    end
  end

  assign o_cur  = r_cur;
  assign o_next = r_cur + 1'b1;
  assign o_done = (r_cur == r_end);

endmodule

`default_nettype wire

// File: rtl/text_terminal_writer.sv
// ============================================================================
// Module   : text_terminal_writer
// Brief    : ASCII stream to character-memory writer with cursor, CR/LF/BS/FF,
//            auto-wrap and bottom scroll. Optional macro: TERM_SCROLL_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module text_terminal_writer
  import term_pkg::*;
#(
  parameter int COLS   = TERM_COLS,
  parameter int ROWS   = TERM_ROWS,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [6:0]        cursor_x,
  output logic [4:0]        cursor_y,
  output logic              busy
);

  localparam logic [6:0]        C_X_LAST       = 7'(COLS - 1);
  localparam logic [4:0]        C_Y_LAST       = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] C_COLS_A       = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] C_ROW0_LAST    = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] C_SCREEN_LAST  = ADDR_W'(ROWS * COLS - 1);
`ifdef TERM_SCROLL_EN
  localparam logic [ADDR_W-1:0] C_MOVE_LAST    = ADDR_W'((ROWS - 1) * COLS - 1);
  localparam logic [ADDR_W-1:0] C_LASTROW_BASE = ADDR_W'((ROWS - 1) * COLS);
`endif

  term_state_e       r_state, w_state_nxt;
  logic              r_req, w_req_nxt;
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [7:0]        r_wdata, w_wdata_nxt;
  logic [6:0]        r_x, w_x_nxt;
  logic [4:0]        r_y, w_y_nxt;
  logic              w_newline;

  logic              w_seq_load;
  logic [ADDR_W-1:0] w_seq_start;
  logic [ADDR_W-1:0] w_seq_end;
  logic              w_seq_step;
  logic [ADDR_W-1:0] w_seq_cur;
  logic [ADDR_W-1:0] w_seq_next;
  logic              w_seq_done;

  logic [6:0]        w_code;
  logic [ADDR_W-1:0] w_cur_addr;

  assign w_code     = in_data[6:0];
  assign w_cur_addr = ADDR_W'(r_y) * C_COLS_A + ADDR_W'(r_x);

  term_addr_seq #(
    .ADDR_W (ADDR_W)
  ) u_addr_seq (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_seq_load),
    .i_start (w_seq_start),
    .i_end   (w_seq_end),
    .i_step  (w_seq_step),
    .o_cur   (w_seq_cur),
    .o_next  (w_seq_next),
    .o_done  (w_seq_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_newline   = 1'b0;
    w_seq_load  = 1'b0;
    w_seq_start = '0;
    w_seq_end   = '0;
    w_seq_step  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          if ((w_code >= CODE_PRINT_LO) && (w_code <= CODE_PRINT_HI)) begin
            w_state_nxt = ST_WRITE;
            w_req_nxt   = 1'b1;
            w_we_nxt    = 1'b1;
            w_addr_nxt  = w_cur_addr;
            w_wdata_nxt = in_data;
          end else if (w_code == CODE_CR) begin
            w_x_nxt = '0;
          end else if (w_code == CODE_LF) begin
            w_newline = 1'b1;
          end else if (w_code == CODE_BS) begin
            if (r_x != '0) w_x_nxt = r_x - 7'd1;
          end else if (w_code == CODE_FF) begin
            w_state_nxt = ST_CLEAR;
            w_req_nxt   = 1'b1;
            w_we_nxt    = 1'b1;
            w_addr_nxt  = '0;
            w_wdata_nxt = CHAR_SPACE;
            w_seq_load  = 1'b1;
            w_seq_end   = C_SCREEN_LAST;
            w_x_nxt     = '0;
            w_y_nxt     = '0;
          end
        end
      end

      ST_WRITE: begin
        if (mem_gnt) begin
          w_state_nxt = ST_IDLE;
          w_req_nxt   = 1'b0;
          if (r_x == C_X_LAST) begin
            w_x_nxt   = '0;
            w_newline = 1'b1;
          end else begin
            w_x_nxt = r_x + 7'd1;
          end
        end
      end

`ifdef TERM_SCROLL_EN
      ST_SCROLL_RD: begin
        if (mem_gnt) begin
          w_state_nxt = ST_SCROLL_CAP;
          w_req_nxt   = 1'b0;
        end
      end

      // Read data is valid the cycle after the grant; capture it here.
      ST_SCROLL_CAP: begin
        w_state_nxt = ST_SCROLL_WR;
        w_req_nxt   = 1'b1;
        w_we_nxt    = 1'b1;
        w_addr_nxt  = w_seq_cur;
        w_wdata_nxt = mem_rdata;
      end

      ST_SCROLL_WR: begin
        if (mem_gnt) begin
          if (w_seq_done) begin
            w_state_nxt = ST_CLEAR;
            w_addr_nxt  = C_LASTROW_BASE;
            w_wdata_nxt = CHAR_SPACE;
            w_seq_load  = 1'b1;
            w_seq_start = C_LASTROW_BASE;
            w_seq_end   = C_SCREEN_LAST;
          end else begin
            w_state_nxt = ST_SCROLL_RD;
            w_we_nxt    = 1'b0;
            w_addr_nxt  = w_seq_next + C_COLS_A;
            w_seq_step  = 1'b1;
          end
        end
      end
`endif

      ST_CLEAR: begin
        if (mem_gnt) begin
          if (w_seq_done) begin
            w_state_nxt = ST_IDLE;
            w_req_nxt   = 1'b0;
          end else begin
            w_addr_nxt = w_seq_next;
            w_seq_step = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase

    // Newline overrides whatever the state branch chose for the last row.
    if (w_newline) begin
      if (r_y != C_Y_LAST) begin
        w_y_nxt = r_y + 5'd1;
      end else begin
`ifdef TERM_SCROLL_EN
        w_state_nxt = ST_SCROLL_RD;
        w_req_nxt   = 1'b1;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = C_COLS_A;
        w_seq_load  = 1'b1;
        w_seq_end   = C_MOVE_LAST;
`else
        w_y_nxt     = '0;
        w_state_nxt = ST_CLEAR;
        w_req_nxt   = 1'b1;
        w_we_nxt    = 1'b1;
        w_addr_nxt  = '0;
        w_wdata_nxt = CHAR_SPACE;
        w_seq_load  = 1'b1;
        w_seq_end   = C_ROW0_LAST;
`endif
      end
    end
  end

`ifndef TERM_SCROLL_EN
  logic w_unused;
  assign w_unused = &{1'b0, mem_rdata, w_seq_cur};
`endif

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = ~in_ready;
  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cursor_x  = r_x;
  assign cursor_y  = r_y;

endmodule

`default_nettype wire

// File: tb/tb_text_terminal_writer.sv
// ============================================================================
// Module   : tb_text_terminal_writer
// Brief    : Directed bench with memory model and write scoreboard for
//            text_terminal_writer. Optional macro: TERM_SCROLL_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_text_terminal_writer;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;
  localparam int LIMIT  = 20000;

  typedef struct packed {
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = 8'h00;
  logic [6:0]        cursor_x;
  logic [4:0]        cursor_y;
  logic              busy;

  logic [7:0]  mem [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  wr_t sb_q[$];
  wr_t mon_e;
  logic sb_on = 1'b0;
  int   wr_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  text_terminal_writer #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_req   (mem_req),
    .mem_gnt   (mem_gnt),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .busy      (busy)
  );

  // Character memory: registered read, one access per granted request.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_req && mem_gnt) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after posedge, so a request seen at negedge is granted next posedge.
  always @(negedge clk) begin
    if (!reset && mem_req && mem_gnt && mem_we) begin
      wr_cnt++;
      if (sb_on) begin
        checks++;
        assert (sb_q.size() != 0) else begin
          errors++;
          $error("FAIL sb_unexpected_write observed=%0h expected=none", mem_addr);
        end
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check("sb_addr", 32'(mem_addr), 32'(mon_e.a));
          check("sb_data", 32'(mem_wdata), 32'(mon_e.d));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int a, input logic [7:0] d);
    wr_t e;
    e.a = 12'(a);
    e.d = d;
    sb_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < LIMIT) begin
      tick();
      n++;
    end
    if (!in_ready) check("send_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < LIMIT) begin
      tick();
      n++;
    end
  endtask

  task automatic preload(input int lo, input int hi, input logic [7:0] v);
    pl_en = 1'b1;
    for (int a = lo; a <= hi; a++) begin
      pl_addr = 12'(a);
      pl_data = v;
      tick();
    end
    pl_en = 1'b0;
  endtask

  function automatic int count_ne(input int lo, input int hi, input logic [7:0] v);
    int c = 0;
    for (int a = lo; a <= hi; a++) if (mem[a] !== v) c++;
    return c;
  endfunction

  task automatic check_cursor(input string tag, input int x, input int y);
    check({tag, "_x"}, 32'(cursor_x), 32'(x));
    check({tag, "_y"}, 32'(cursor_y), 32'(y));
  endtask

  initial begin
    int n;
    int w0;
    int rq;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    mem_gnt  = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check_cursor("rst_cur", 0, 0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);

    // Printing with wrap at the line end
    sb_on = 1'b1;
    push(0, 8'h41);
    send(8'h41);
    wait_ready(n);
    check("print_busy_cycles", 32'(n), 32'd1);
    push(1, 8'h42);
    send(8'h42);
    wait_ready(n);
    check_cursor("after_AB", 2, 0);
    for (int i = 2; i < COLS; i++) begin
      push(i, 8'h78);
      send(8'h78);
    end
    wait_ready(n);
    check_cursor("after_wrap", 0, 1);
    check("wrap_write_count", 32'(wr_cnt), 32'd80);
    check("sb_drained_1", 32'(sb_q.size()), 32'd0);

    // CR / LF / BS
    push(80, 8'h51);
    send(8'h51);
    wait_ready(n);
    w0 = wr_cnt;
    send(8'h0D);
    check("cr_no_busy", 32'(in_ready), 32'd1);
    check_cursor("after_cr", 0, 1);
    send(8'h0A);
    check_cursor("after_lf", 0, 2);
    send(8'h08);
    check_cursor("bs_at_col0", 0, 2);
    check("ctrl_no_writes", 32'(wr_cnt), 32'(w0));
    send(8'h0A);
    for (int i = 0; i < 5; i++) begin
      push(3 * COLS + i, 8'h79);
      send(8'h79);
    end
    wait_ready(n);
    check_cursor("at_5_3", 5, 3);
    send(8'h08);
    check_cursor("bs_5_3", 4, 3);

    // Grant stall
    w0 = wr_cnt;
    mem_gnt = 1'b0;
    push(3 * COLS + 4, 8'h5A);
    send(8'h5A);
    for (int k = 0; k < 5; k++) begin
      check("stall_req", 32'(mem_req), 32'd1);
      check("stall_addr", 32'(mem_addr), 32'(3 * COLS + 4));
      check("stall_wdata", 32'(mem_wdata), 32'h5A);
      check("stall_cursor_x", 32'(cursor_x), 32'd4);
      tick();
    end
    mem_gnt = 1'b1;
    tick();
    check("stall_cursor_after", 32'(cursor_x), 32'd5);
    check("stall_ready_after", 32'(in_ready), 32'd1);
    check("stall_one_write", 32'(wr_cnt), 32'(w0 + 1));
    check("sb_drained_2", 32'(sb_q.size()), 32'd0);

    // Form feed and highlight bit
    sb_on = 1'b0;
    w0 = wr_cnt;
    send(8'h0C);
    wait_ready(n);
    check("ff_cycles", 32'(n), 32'd2400);
    check("ff_all_space", 32'(count_ne(0, 2399, 8'h20)), 32'd0);
    check("ff_write_count", 32'(wr_cnt - w0), 32'd2400);
    check_cursor("after_ff", 0, 0);
    sb_on = 1'b1;
    push(0, 8'hC1);
    send(8'hC1);
    wait_ready(n);
    check("highlight_stored", 32'(mem[0]), 32'hC1);
    check_cursor("after_hl", 1, 0);
    sb_on = 1'b0;
    send(8'h0C);
    wait_ready(n);
    check("ff2_cycles", 32'(n), 32'd2400);
    check("ff2_addr0", 32'(mem[0]), 32'h20);
    check_cursor("after_ff2", 0, 0);
    w0 = wr_cnt;
    send(8'h07);
    check("bel_ignored_ready", 32'(in_ready), 32'd1);
    send(8'h7F);
    check("del_ignored_ready", 32'(in_ready), 32'd1);
    check_cursor("after_ignored", 0, 0);
    check("ignored_no_writes", 32'(wr_cnt), 32'(w0));

    // Newline on the last row
    preload(COLS, 2 * COLS - 1, 8'h31);
    preload((ROWS - 1) * COLS, ROWS * COLS - 1, 8'h55);
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
    check_cursor("at_last_row", 0, ROWS - 1);
    send(8'h0A);
    wait_ready(n);
`ifdef TERM_SCROLL_EN
    check("scroll_cycles", 32'(n), 32'd7040);
    check("scroll_row0", 32'(count_ne(0, 79, 8'h31)), 32'd0);
    check("scroll_row28", 32'(count_ne(2240, 2319, 8'h55)), 32'd0);
    check("scroll_row29", 32'(count_ne(2320, 2399, 8'h20)), 32'd0);
    check_cursor("after_scroll", 0, ROWS - 1);
`else
    check("wrap_clear_cycles", 32'(n), 32'd80);
    check("wrap_row0", 32'(count_ne(0, 79, 8'h20)), 32'd0);
    check("wrap_row1_kept", 32'(count_ne(80, 159, 8'h31)), 32'd0);
    check("wrap_row29_kept", 32'(count_ne(2320, 2399, 8'h55)), 32'd0);
    check_cursor("after_wrap_clear", 0, 0);
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
`endif

    // Printable byte at the very last cell
    preload(0, COLS - 1, 8'h66);
    sb_on = 1'b1;
    for (int i = 0; i < COLS - 1; i++) begin
      push((ROWS - 1) * COLS + i, 8'h77);
      send(8'h77);
    end
    wait_ready(n);
    check_cursor("at_corner", COLS - 1, ROWS - 1);
    check("sb_drained_3", 32'(sb_q.size()), 32'd0);
    sb_on = 1'b0;
    send(8'h45);
    wait_ready(n);
`ifdef TERM_SCROLL_EN
    check("corner_cycles", 32'(n), 32'd7041);
    check("corner_moved_char", 32'(mem[2319]), 32'h45);
    check("corner_moved_row", 32'(count_ne(2240, 2318, 8'h77)), 32'd0);
    check("corner_row29", 32'(count_ne(2320, 2399, 8'h20)), 32'd0);
    check_cursor("after_corner", 0, ROWS - 1);
`else
    check("corner_cycles", 32'(n), 32'd81);
    check("corner_char", 32'(mem[2399]), 32'h45);
    check("corner_row0", 32'(count_ne(0, 79, 8'h20)), 32'd0);
    check_cursor("after_corner", 0, 0);
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
`endif

    // Reset in the middle of a long operation
    for (int i = 0; i < 3; i++) send(8'h6B);
    send(8'h0A);
`ifdef TERM_SCROLL_EN
    repeat (100) tick();
`else
    repeat (40) tick();
`endif
    check("midop_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    check("midrst_req", 32'(mem_req), 32'd0);
    check_cursor("midrst_cur", 0, 0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    rq = 0;
    repeat (20) begin
      tick();
      if (mem_req) rq++;
    end
    check("midrst_no_req", 32'(rq), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
